vscale_htif_pcr_master: RTL and testbench

VSCALE_HTIF_PCR_MASTER -- requirements
Module: vscale_htif_pcr_master

---
 rtl/vscale_htif_pcr_master_if.sv | 49 ++++
 rtl/vscale_htif_pcr_master.sv | 171 +++++++++++++++++
 tb/tb_vscale_htif_pcr_master.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vscale_htif_pcr_master_if.sv
// Signal bundle for vscale_htif_pcr_master: the local command/result channel
// and the PCR request/response channel towards the core.
// master = the PCR master block, slave = its environment (host side + core).

`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef HTIF_PCR_WIDTH
`define HTIF_PCR_WIDTH 64
`endif

interface vscale_htif_pcr_master_if;
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_rw;
  logic [`CSR_ADDR_WIDTH-1:0] cmd_addr;
  logic [`HTIF_PCR_WIDTH-1:0] cmd_wdata;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [`HTIF_PCR_WIDTH-1:0] rsp_data;
  logic                       rsp_timeout;

  logic                       htif_pcr_req_valid;
  logic                       htif_pcr_req_ready;
  logic                       htif_pcr_req_rw;
  logic [`CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr;
  logic [`HTIF_PCR_WIDTH-1:0] htif_pcr_req_data;

  logic                       htif_pcr_resp_valid;
  logic                       htif_pcr_resp_ready;
  logic [`HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
           htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
           htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
           htif_pcr_resp_ready
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready,
           htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
           htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
           htif_pcr_resp_ready
  );
endinterface

// File: rtl/vscale_htif_pcr_master.sv
// vscale_htif_pcr_master: turns one local command at a time into a PCR
// request/response exchange with the core and hands the result back.
// Optional feature macro: VSCALE_HTIF_PCR_TIMEOUT_EN -- aborts a transaction
// after TIMEOUT_CYCLES cycles in REQ/RESP and drains the late core response.

`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef HTIF_PCR_WIDTH
`define HTIF_PCR_WIDTH 64
`endif

module vscale_htif_pcr_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  vscale_htif_pcr_master_if.master bus
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                     state_q, state_d;
  logic                       rw_q, rw_d;
  logic [`CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [`HTIF_PCR_WIDTH-1:0] wdata_q, wdata_d;
  logic [`HTIF_PCR_WIDTH-1:0] rdata_q, rdata_d;
  logic                       cmd_open;

`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
  localparam logic [16:0] LIMIT = 17'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;
  logic [16:0] elapsed;
  logic        expired;
  logic        timeout_q, timeout_d;
  logic        stale_q, stale_d;
  logic        draining;

  // elapsed counts the current REQ/RESP cycle too, so expiry lands on cycle TIMEOUT_CYCLES
  assign elapsed  = {1'b0, cnt_q} + 17'd1;
  assign expired  = (elapsed >= LIMIT);
  assign draining = stale_q && ((state_q == IDLE) || (state_q == DONE));
  assign cmd_open = (state_q == IDLE) && !stale_q;

  assign bus.htif_pcr_resp_ready = (state_q == RESP) || draining;
  assign bus.rsp_timeout         = timeout_q;
`else
  assign cmd_open = (state_q == IDLE);

  assign bus.htif_pcr_resp_ready = (state_q == RESP);
  assign bus.rsp_timeout         = 1'b0;
`endif

  assign bus.cmd_ready          = cmd_open && !reset;
  assign bus.htif_pcr_req_valid = (state_q == REQ);
  assign bus.htif_pcr_req_rw    = (state_q == REQ) && rw_q;
  assign bus.htif_pcr_req_addr  = (state_q == REQ) ? addr_q : '0;
  assign bus.htif_pcr_req_data  = (state_q == REQ) ? wdata_q : '0;
  assign bus.rsp_valid          = (state_q == DONE);
  assign bus.rsp_data           = rdata_q;

  // Next-state and datapath updates; a handshake in the expiry cycle wins over the timeout
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    stale_d   = stale_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_open) begin
          rw_d    = bus.cmd_rw;
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          state_d = REQ;
`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
        cnt_d = elapsed[15:0];
`endif
        if (bus.htif_pcr_req_ready) begin
          state_d = RESP;
        end
`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
        else if (expired) begin
          state_d   = DONE;
          rdata_d   = '0;
          timeout_d = 1'b1;
        end
`endif
      end
      RESP: begin
`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
        cnt_d = elapsed[15:0];
`endif
        if (bus.htif_pcr_resp_valid) begin
          rdata_d = bus.htif_pcr_resp_data;
          state_d = DONE;
`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
        else if (expired) begin
          state_d   = DONE;
          rdata_d   = '0;
          timeout_d = 1'b1;
          stale_d   = 1'b1;
        end
`endif
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
    endcase
`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
    if (draining && bus.htif_pcr_resp_valid) begin
      stale_d = 1'b0;
    end
`endif
  end

  // State and latched transaction fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
  // Timeout counter, timeout flag and stale-response flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      stale_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      stale_q   <= stale_d;
    end
  end
`endif

endmodule

// File: tb/tb_vscale_htif_pcr_master.sv
// Self-checking bench for vscale_htif_pcr_master. Each transaction's expected
// waveform is derived from the stall counts chosen for the core and the host:
// request window, response window, result window, and ready return.

`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef HTIF_PCR_WIDTH
`define HTIF_PCR_WIDTH 64
`endif

module tb_vscale_htif_pcr_master;

  localparam int unsigned TO = 8;

  typedef logic [`CSR_ADDR_WIDTH-1:0] addr_t;
  typedef logic [`HTIF_PCR_WIDTH-1:0] data_t;

  logic clk;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  vscale_htif_pcr_master_if bus ();

  vscale_htif_pcr_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic data_t rand_data();
    return data_t'({$urandom, $urandom});
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid           = 1'b0;
    bus.htif_pcr_req_ready  = 1'b0;
    bus.htif_pcr_resp_valid = 1'b0;
    bus.rsp_ready           = 1'b0;
  endtask

  task automatic scramble_cmd(input bit force_valid);
    bus.cmd_valid = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
    bus.cmd_rw    = 1'($urandom_range(0, 1));
    bus.cmd_addr  = addr_t'($urandom);
    bus.cmd_wdata = rand_data();
  endtask

  // One complete transaction: core stalls req by dr, resp by dp; host stalls result by dk
  task automatic run_txn(input logic rw, input addr_t addr, input data_t wdata, input data_t core,
                         input int unsigned dr, input int unsigned dp, input int unsigned dk);
    int unsigned last;
    last = 3 + dr + dp + dk;
    check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    for (int unsigned t = 1; t <= last; t++) begin
      bit in_req;
      bit in_resp;
      bit in_done;
      tick();
      in_req  = (t <= 1 + dr);
      in_resp = (t >= 2 + dr) && (t <= 2 + dr + dp);
      in_done = (t >= 3 + dr + dp);
      check("cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
      check("req_valid", 64'(bus.htif_pcr_req_valid), 64'(in_req));
      check("req_rw", 64'(bus.htif_pcr_req_rw), in_req ? 64'(rw) : 64'd0);
      check("req_addr", 64'(bus.htif_pcr_req_addr), in_req ? 64'(addr) : 64'd0);
      check("req_data", 64'(bus.htif_pcr_req_data), in_req ? 64'(wdata) : 64'd0);
      check("resp_ready", 64'(bus.htif_pcr_resp_ready), 64'(in_resp));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(in_done));
      if (in_done) begin
        check("rsp_data", 64'(bus.rsp_data), 64'(core));
        check("rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
      end
      bus.htif_pcr_req_ready  = (t == 1 + dr);
      bus.htif_pcr_resp_valid = (t == 2 + dr + dp);
      bus.htif_pcr_resp_data  = (t == 2 + dr + dp) ? core : rand_data();
      bus.rsp_ready           = (t == last);
      scramble_cmd(in_done);
    end
    tick();
    idle_inputs();
  endtask

`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
  // Core never answers; req_accepts selects whether the expiry hits in REQ or RESP
  task automatic run_timeout(input bit req_accepts, input int unsigned dk, input int unsigned late);
    int unsigned last;
    last = TO + 1 + dk;
    check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = addr_t'($urandom);
    bus.cmd_wdata = rand_data();
    for (int unsigned t = 1; t <= last; t++) begin
      bit exp_req;
      tick();
      exp_req = req_accepts ? (t == 1) : (t <= TO);
      check("to_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      check("to_req_valid", 64'(bus.htif_pcr_req_valid), 64'(exp_req));
      check("to_resp_ready", 64'(bus.htif_pcr_resp_ready), 64'(req_accepts && (t >= 2)));
      check("to_rsp_valid", 64'(bus.rsp_valid), 64'(t >= TO + 1));
      if (t >= TO + 1) begin
        check("to_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("to_rsp_timeout", 64'(bus.rsp_timeout), 64'd1);
      end
      bus.htif_pcr_req_ready  = req_accepts && (t == 1);
      bus.htif_pcr_resp_valid = 1'b0;
      bus.htif_pcr_resp_data  = rand_data();
      bus.rsp_ready           = (t == last);
      scramble_cmd(1'b0);
    end
    if (req_accepts) begin
      for (int unsigned u = 0; u <= late; u++) begin
        tick();
        check("stale_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("stale_resp_ready", 64'(bus.htif_pcr_resp_ready), 64'd1);
        check("stale_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("stale_req_valid", 64'(bus.htif_pcr_req_valid), 64'd0);
        bus.rsp_ready           = 1'b0;
        bus.htif_pcr_resp_valid = (u == late);
        bus.htif_pcr_resp_data  = rand_data();
        scramble_cmd(1'b1);
      end
    end
    tick();
    idle_inputs();
  endtask
`endif

  // Reset lands while the block waits for the core's response
  task automatic reset_mid_resp();
    check("rst_cmd_ready_pre", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = addr_t'($urandom);
    bus.cmd_wdata = rand_data();
    tick();
    bus.cmd_valid          = 1'b0;
    bus.htif_pcr_req_ready = 1'b1;
    tick();
    bus.htif_pcr_req_ready = 1'b0;
    check("rst_in_resp", 64'(bus.htif_pcr_resp_ready), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_resp_ready", 64'(bus.htif_pcr_resp_ready), 64'd0);
    check("rst_req_valid", 64'(bus.htif_pcr_req_valid), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_release_ready", 64'(bus.cmd_ready), 64'd1);
    bus.htif_pcr_resp_valid = 1'b1;
    bus.htif_pcr_resp_data  = rand_data();
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      bus.htif_pcr_resp_valid = 1'b0;
      check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("post_rst_resp_ready", 64'(bus.htif_pcr_resp_ready), 64'd0);
      check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    end
  endtask

  initial begin
    int unsigned max_stall;
`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
    max_stall = 3;
`else
    max_stall = 12;
`endif
    reset = 1'b1;
    idle_inputs();
    bus.cmd_rw             = 1'b0;
    bus.cmd_addr           = '0;
    bus.cmd_wdata          = '0;
    bus.htif_pcr_resp_data = '0;
    tick();
    tick();
    check("reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("reset_req_valid", 64'(bus.htif_pcr_req_valid), 64'd0);
    check("reset_resp_ready", 64'(bus.htif_pcr_resp_ready), 64'd0);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
    check("reset_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    reset = 1'b0;
    #1;
    check("release_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    run_txn(1'b0, addr_t'(12'h780), rand_data(), data_t'(64'h0000_0000_DEAD_BEEF), 0, 0, 0);
    run_txn(1'b1, addr_t'(12'h51E), data_t'(64'h1), rand_data(), 5, 0, 0);
    run_txn(1'b0, addr_t'($urandom), rand_data(), rand_data(), 0, 1, 10);

`ifdef VSCALE_HTIF_PCR_TIMEOUT_EN
    run_timeout(1'b1, 2, 3);
    run_txn(1'b0, addr_t'($urandom), rand_data(), rand_data(), 0, 0, 0);
    run_timeout(1'b0, 1, 0);
    run_txn(1'b0, addr_t'($urandom), rand_data(), rand_data(), 1, 1, 1);
    run_timeout(1'b1, 0, 0);
    run_txn(1'b1, addr_t'($urandom), rand_data(), rand_data(), 0, 2, 0);
`endif

    for (int unsigned i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), addr_t'($urandom), rand_data(), rand_data(),
              $urandom_range(0, max_stall), $urandom_range(0, max_stall), $urandom_range(0, 4));
    end

    reset_mid_resp();
    run_txn(1'b0, addr_t'($urandom), rand_data(), rand_data(), 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
